// File: rtl/led_seq_pkg.sv
// Shared mode codes, per-mode initial patterns and bounce direction for the
// LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_BLINK  = 3'd1,
    MODE_CHASE  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [3:0] PAT_INIT_OFF    = 4'b0000;
  localparam logic [3:0] PAT_INIT_BLINK  = 4'b1111;
  localparam logic [3:0] PAT_INIT_CHASE  = 4'b0001;
  localparam logic [3:0] PAT_INIT_BOUNCE = 4'b0001;
  localparam logic [3:0] PAT_INIT_COUNT  = 4'b0000;

  // Unreachable codes fall through to OFF so the FSM self-recovers.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:    return MODE_BLINK;
      MODE_BLINK:  return MODE_CHASE;
      MODE_CHASE:  return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_COUNT;
      default:     return MODE_OFF;
    endcase
  endfunction

  function automatic logic [3:0] init_pattern(input mode_t m);
    case (m)
      MODE_BLINK:  return PAT_INIT_BLINK;
      MODE_CHASE:  return PAT_INIT_CHASE;
      MODE_BOUNCE: return PAT_INIT_BOUNCE;
      MODE_COUNT:  return PAT_INIT_COUNT;
      default:     return PAT_INIT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_tick_gen.sv
// Prescaler producing a one-cycle step tick every g_STEP_COUNT enabled clocks.
module step_tick_gen #(
  parameter int g_STEP_COUNT = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CW = $clog2(g_STEP_COUNT);
  localparam logic [CW-1:0] LAST = CW'(g_STEP_COUNT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      cnt_q <= '0;
    end else if (i_Enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign o_Tick = i_Enable && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Mode FSM and pattern register driving the four Go Board LEDs, paced by a
// single shared step tick.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int g_STEP_COUNT = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Next,
  input  logic       i_Enable,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [2:0] o_Mode
);

  mode_t      mode_q, mode_d;
  dir_t       dir_q, dir_d;
  logic [3:0] pat_q, pat_d;
  logic       tick;

  step_tick_gen #(
    .g_STEP_COUNT(g_STEP_COUNT)
  ) u_step_tick_gen (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Enable(i_Enable),
    .i_Clear (i_Next),
    .o_Tick  (tick)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mode_q <= MODE_OFF;
      dir_q  <= DIR_UP;
      pat_q  <= PAT_INIT_OFF;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
    end
  end

  // i_Next outranks a coincident tick: the tick is dropped and the new
  // mode starts from its initial pattern.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    if (i_Next) begin
      mode_d = next_mode(mode_q);
      dir_d  = DIR_UP;
      pat_d  = init_pattern(next_mode(mode_q));
    end else begin
      case (mode_q)
        MODE_OFF: pat_d = PAT_INIT_OFF;
        MODE_BLINK: if (tick) pat_d = ~pat_q;
        MODE_CHASE: if (tick) pat_d = {pat_q[2:0], pat_q[3]};
        MODE_BOUNCE: begin
          if (tick) begin
            if (dir_q == DIR_UP) begin
              if (pat_q == 4'b1000) begin
                dir_d = DIR_DOWN;
                pat_d = {1'b0, pat_q[3:1]};
              end else begin
                pat_d = {pat_q[2:0], 1'b0};
              end
            end else begin
              if (pat_q == 4'b0001) begin
                dir_d = DIR_UP;
                pat_d = {pat_q[2:0], 1'b0};
              end else begin
                pat_d = {1'b0, pat_q[3:1]};
              end
            end
          end
        end
        MODE_COUNT: if (tick) pat_d = pat_q + 4'd1;
        default: begin
          mode_d = MODE_OFF;
          dir_d  = DIR_UP;
          pat_d  = PAT_INIT_OFF;
        end
      endcase
    end
  end

  assign o_LED_1 = pat_q[0];
  assign o_LED_2 = pat_q[1];
  assign o_LED_3 = pat_q[2];
  assign o_LED_4 = pat_q[3];
  assign o_Mode  = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus queues the expected post-edge LED/mode values,
// a monitor pops and compares one entry after every rising edge.
module tb_led_pattern_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_Next = 1'b0;
  logic       i_Enable = 1'b0;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [2:0] o_Mode;

  typedef struct {
    logic [3:0] led;
    logic [2:0] mode;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  led_pattern_sequencer #(
    .g_STEP_COUNT(4)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Next  (i_Next),
    .i_Enable(i_Enable),
    .o_LED_1 (o_LED_1),
    .o_LED_2 (o_LED_2),
    .o_LED_3 (o_LED_3),
    .o_LED_4 (o_LED_4),
    .o_Mode  (o_Mode)
  );

  always #5 i_Clk = ~i_Clk;

  // Monitor: one expectation per clock, checked just after the edge.
  always @(posedge i_Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] led;
      e   = exp_q.pop_front();
      led = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};
      n_checks++;
      if (led === e.led && o_Mode === e.mode) n_pass++;
      else $display("FAIL %s: got led=%b mode=%0d, expected led=%b mode=%0d",
                    e.name, led, o_Mode, e.led, e.mode);
    end
  end

  // Drive one clock of inputs and queue the value expected after that edge.
  task automatic cyc(input logic nx, input logic en, input logic rst,
                     input logic [3:0] led, input logic [2:0] md, input string nm);
    exp_t e;
    @(negedge i_Clk);
    i_Next = nx; i_Enable = en; i_Rst = rst;
    e.led = led; e.mode = md; e.name = nm;
    exp_q.push_back(e);
  endtask

  logic [3:0] bounce_seq [8];
  logic [3:0] v;

  initial begin
    bounce_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0100, 4'b0010, 4'b0001, 4'b0010};

    cyc(0, 0, 1, 4'b0000, 3'd0, "reset0");
    cyc(0, 1, 1, 4'b0000, 3'd0, "reset1");

    // 1: reach COUNT (i_Next while disabled), count to 0101, reset mid-step
    cyc(1, 0, 0, 4'b1111, 3'd1, "s1_next_blink");
    cyc(1, 0, 0, 4'b0001, 3'd2, "s1_next_chase");
    cyc(1, 0, 0, 4'b0001, 3'd3, "s1_next_bounce");
    cyc(1, 0, 0, 4'b0000, 3'd4, "s1_next_count");
    for (int j = 1; j <= 22; j++) begin
      v = 4'(j / 4);
      cyc(0, 1, 0, v, 3'd4, "s1_count");
    end
    cyc(0, 1, 1, 4'b0000, 3'd0, "s1_reset_mid");
    for (int j = 1; j <= 20; j++) cyc(0, 1, 0, 4'b0000, 3'd0, "s1_off_hold");

    // 2: BLINK toggles every 4 clocks
    cyc(1, 1, 0, 4'b1111, 3'd1, "s2_enter_blink");
    for (int j = 1; j <= 12; j++) begin
      v = ((j / 4) % 2 == 0) ? 4'b1111 : 4'b0000;
      cyc(0, 1, 0, v, 3'd1, "s2_blink");
    end

    // 3: BOUNCE sequence
    cyc(1, 1, 0, 4'b0001, 3'd2, "s3_enter_chase");
    cyc(1, 1, 0, 4'b0001, 3'd3, "s3_enter_bounce");
    for (int j = 1; j <= 28; j++) cyc(0, 1, 0, bounce_seq[j / 4], 3'd3, "s3_bounce");

    // 4: COUNT wraps after 16 ticks, then back to OFF
    cyc(1, 1, 0, 4'b0000, 3'd4, "s4_enter_count");
    for (int j = 1; j <= 70; j++) begin
      v = 4'((j / 4) % 16);
      cyc(0, 1, 0, v, 3'd4, "s4_count");
    end
    cyc(1, 1, 0, 4'b0000, 3'd0, "s4_wrap_off");

    // 5: i_Next on the tick cycle in CHASE at 0100
    cyc(1, 1, 0, 4'b1111, 3'd1, "s5_enter_blink");
    cyc(1, 1, 0, 4'b0001, 3'd2, "s5_enter_chase");
    for (int j = 1; j <= 11; j++) begin
      v = (j < 4) ? 4'b0001 : (j < 8) ? 4'b0010 : 4'b0100;
      cyc(0, 1, 0, v, 3'd2, "s5_chase");
    end
    cyc(1, 1, 0, 4'b0001, 3'd3, "s5_next_on_tick");
    for (int j = 1; j <= 4; j++) begin
      v = (j < 4) ? 4'b0001 : 4'b0010;
      cyc(0, 1, 0, v, 3'd3, "s5_bounce_after");
    end

    // 6: freeze CHASE at 0010 mid-step, resume without skip/double step
    cyc(1, 1, 0, 4'b0000, 3'd4, "s6_to_count");
    cyc(1, 1, 0, 4'b0000, 3'd0, "s6_to_off");
    cyc(1, 1, 0, 4'b1111, 3'd1, "s6_to_blink");
    cyc(1, 1, 0, 4'b0001, 3'd2, "s6_to_chase");
    for (int j = 1; j <= 6; j++) begin
      v = (j < 4) ? 4'b0001 : 4'b0010;
      cyc(0, 1, 0, v, 3'd2, "s6_chase");
    end
    for (int j = 1; j <= 10; j++) cyc(0, 0, 0, 4'b0010, 3'd2, "s6_frozen");
    cyc(0, 1, 0, 4'b0010, 3'd2, "s6_resume_cnt3");
    cyc(0, 1, 0, 4'b0100, 3'd2, "s6_resume_step");
    for (int j = 1; j <= 3; j++) cyc(0, 1, 0, 4'b0100, 3'd2, "s6_hold");
    cyc(0, 1, 0, 4'b1000, 3'd2, "s6_next_step");

    // Reset beats a simultaneous i_Next
    cyc(1, 1, 1, 4'b0000, 3'd0, "rst_beats_next");
    cyc(0, 1, 0, 4'b0000, 3'd0, "after_rst");

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge i_Clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
